imem_loader: RTL
================

# imem_loader

Boot-time program loader and IMEM write-port owner. Accepts a byte stream (length header, then instruction bytes) over a valid/ready handshake, assembles little-endian 32-bit words and writes them to consecutive IMEM word addresses through the IMEM write port. Holds the core stalled until the program is fully written, then releases it. Sits between the host link (e.g. UART RX) and the IMEM `wr_en`/`wr_addr`/`wr_data` inputs, next to the core's fetch stage.

## Interface
- `PC_WIDTH`, 32, IMEM byte-address width; drives `wr_addr`.
- `INST_WIDTH`, 32, instruction width; drives `wr_data`.
- `BASE_ADDR`, 0, byte address of the first word written; must be a multiple of 4.
- `MAX_WORDS`, 256, largest accepted program length in words.
- `CNT_WIDTH`, 16, width of `words_loaded`; must satisfy 2^CNT_WIDTH > MAX_WORDS.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `load_start`  in  1  single-cycle request to begin a load.
- `in_valid`  in  1  byte on `in_data` is valid.
- `in_data`  in  8  stream byte.
- `in_ready`  out  1  loader accepts a byte this cycle.
- `wr_en`  out  1  IMEM write strobe; one cycle per word.
- `wr_addr`  out  PC_WIDTH  IMEM byte address of the word.
- `wr_data`  out  INST_WIDTH  word; `in_data` byte 0 goes to bits [7:0].
- `core_hold`  out  1  stalls the core and holds it at reset PC while 1.
- `load_done`  out  1  program loaded; level signal.
- `load_err`  out  1  header length exceeded MAX_WORDS; sticky.
- `words_loaded`  out  CNT_WIDTH  words written in the current load.
- `checksum`  out  8  modulo-256 sum of all data bytes accepted (header excluded).

## Operation
- States: IDLE, HDR, DATA, WRITE, DONE, ERR.
- A byte transfers when `in_valid & in_ready` is high at a rising edge. `in_ready` is high only in HDR and DATA.
- IDLE: `core_hold`=1. `load_start` -> HDR. Clear `words_loaded` and `checksum`, and zero the byte index.
- HDR: accept 4 bytes, assembled little-endian into N (32 bits). On the 4th byte:
  - N==0 -> DONE.
  - N>MAX_WORDS -> ERR (full 32-bit compare).
  - otherwise -> DATA.
- DATA: accept bytes into word-assembly lanes 0..3 and add each byte to `checksum`. On the 4th byte -> WRITE.
- WRITE: one cycle. Drive `wr_en`=1, `wr_addr`=BASE_ADDR+4*`words_loaded`, `wr_data`=assembled word. Then increment `words_loaded`.
  - If the new count equals N -> DONE.
  - Otherwise -> DATA.
- DONE: `core_hold`=0, `load_done`=1. `load_start` -> HDR, which re-asserts `core_hold` and clears `load_done`, `words_loaded` and `checksum`.
- ERR: `load_err`=1, `core_hold`=1, `in_ready`=0. `load_start` -> HDR and clears `load_err`.
- `load_start` is ignored in HDR, DATA and WRITE.
- `wr_addr` arithmetic wraps modulo 2^PC_WIDTH.
- `wr_addr` and `wr_data` hold their last values when `wr_en`=0.

## Timing
- Reset values (next edge with `reset`=1, regardless of state):
  - state IDLE
  - `in_ready`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0
  - `core_hold`=1, `load_done`=0, `load_err`=0
  - `words_loaded`=0, `checksum`=0
- Reset mid-load abandons the load. Partially written IMEM contents are not rolled back.
- All outputs are registered.
- `in_ready` rises the cycle after `load_start` is sampled.
- `wr_en` is asserted the cycle after the 4th data byte's handshake. `in_ready`=0 during that WRITE cycle.
- Peak throughput is 4 bytes per 5 cycles. Gaps on `in_valid` stall assembly without losing partial bytes.
- `core_hold` falls, and `load_done` rises, the cycle after the final WRITE (or after the 4th header byte when N==0).
- `words_loaded` updates on the same edge that ends WRITE.
- `checksum` updates on the edge of each data-byte handshake.

## Test plan
- Reset: assert `reset` for 2 cycles mid-DATA -> all outputs at reset values, `core_hold`=1, `in_ready`=0 next cycle.
- Normal load, BASE_ADDR=0:
  - Stimulus: `load_start`, then bytes 02 00 00 00 | 13 00 00 00 | 93 00 10 00.
  - Two `wr_en` pulses: (0x0, 0x00000013), then (0x4, 0x00100093).
  - Then `load_done`=1, `core_hold`=0, `words_loaded`=2, `checksum`=0xB6.
- Empty program: header 00 00 00 00 -> no `wr_en`; `load_done`=1 the cycle after the 4th byte.
- Oversize: header 01 01 00 00 (257 > 256) -> ERR, `load_err`=1, `in_ready`=0, `core_hold`=1. A following `load_start` clears `load_err` and accepts a new header.
- Backpressure and gaps: random `in_valid` gaps between bytes -> identical writes to the normal case. `in_ready`=0 exactly in WRITE cycles. A `load_start` pulsed during DATA has no effect.
- Reload: from DONE, `load_start` with N=1, word 0xDEADBEEF -> `core_hold` re-asserted; write (0x0, 0xDEADBEEF); `words_loaded`=1, `checksum`=0x38.

Source files
------------

// File: rtl/imem_loader.sv
// imem_loader: boot-time program loader. Takes a byte stream (4-byte LE length
// header followed by instruction bytes), packs little-endian 32-bit words and
// writes them to consecutive IMEM word addresses while holding the core stalled.
module imem_loader #(
  parameter int unsigned         PC_WIDTH   = 32,
  parameter int unsigned         INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int unsigned         MAX_WORDS  = 256,
  parameter int unsigned         CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  wr_en,
  output logic [PC_WIDTH-1:0]   wr_addr,
  output logic [INST_WIDTH-1:0] wr_data,
  output logic                  core_hold,
  output logic                  load_done,
  output logic                  load_err,
  output logic [CNT_WIDTH-1:0]  words_loaded,
  output logic [7:0]            checksum
);

  typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_t;

  state_t      state;
  logic [1:0]  byte_idx;   // byte lane of the next accepted byte
  logic [31:0] shift;      // header / word assembly, bytes shift in from the top
  logic [31:0] hdr_n;      // program length in words
  logic        xfer;
  logic [31:0] asm_next;
  logic [31:0] cnt_next;

  assign xfer     = in_valid & in_ready;
  // Shifting each byte in at the top leaves byte 0 in [7:0] after four bytes.
  assign asm_next = {in_data, shift[31:8]};
  assign cnt_next = 32'(words_loaded) + 32'd1;

  // Loader FSM; every output is a register updated alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      byte_idx     <= '0;
      shift        <= '0;
      hdr_n        <= '0;
      in_ready     <= 1'b0;
      wr_en        <= 1'b0;
      wr_addr      <= '0;
      wr_data      <= '0;
      core_hold    <= 1'b1;
      load_done    <= 1'b0;
      load_err     <= 1'b0;
      words_loaded <= '0;
      checksum     <= '0;
    end else begin
      wr_en <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (load_start) begin
            state        <= HDR;
            in_ready     <= 1'b1;
            core_hold    <= 1'b1;
            load_done    <= 1'b0;
            load_err     <= 1'b0;
            words_loaded <= '0;
            checksum     <= '0;
            byte_idx     <= '0;
          end
        end
        HDR: begin
          if (xfer) begin
            shift    <= asm_next;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              hdr_n <= asm_next;
              if (asm_next == 32'd0) begin
                state     <= DONE;
                in_ready  <= 1'b0;
                core_hold <= 1'b0;
                load_done <= 1'b1;
              end else if (asm_next > MAX_WORDS) begin
                state    <= ERR;
                in_ready <= 1'b0;
                load_err <= 1'b1;
              end else begin
                state <= DATA;
              end
            end
          end
        end
        DATA: begin
          if (xfer) begin
            shift    <= asm_next;
            byte_idx <= byte_idx + 2'd1;
            checksum <= checksum + in_data;
            if (byte_idx == 2'd3) begin
              state    <= WRITE;
              in_ready <= 1'b0;
              wr_en    <= 1'b1;
              wr_addr  <= BASE_ADDR + PC_WIDTH'({words_loaded, 2'b00});
              wr_data  <= INST_WIDTH'(asm_next);
            end
          end
        end
        WRITE: begin
          words_loaded <= words_loaded + 1'b1;
          if (cnt_next == hdr_n) begin
            state     <= DONE;
            core_hold <= 1'b0;
            load_done <= 1'b1;
          end else begin
            state    <= DATA;
            in_ready <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
